// File: rtl/ex_stage_mdu_pkg.sv
// Shared execute-stage definitions: MDU op codes,
// ALU control encodings and datapath width default.
package ex_stage_mdu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd12;

endpackage

// File: rtl/ex_stage_mdu_core.sv
// Multiply/divide unit: IDLE/RUN FSM, latency counter,
// HI/LO registers. Results are computed at start.
module mdu_core
  import ex_stage_mdu_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int MAXC =
    (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNTW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state;
  logic [CNTW-1:0]   count;
  logic [WIDTH-1:0]  hiQ, loQ;
  logic [WIDTH-1:0]  hiSh, loSh;
  logic              shWe;

  logic isMul, isDiv, isLong, isSigned, launch;
  logic doMthi, doMtlo;

  assign isMul    = (op == MDU_MULT) || (op == MDU_MULTU);
  assign isDiv    = (op == MDU_DIV) || (op == MDU_DIVU);
  assign isLong   = isMul || isDiv;
  assign isSigned = (op == MDU_MULT) || (op == MDU_DIV);
  assign launch   = start && isLong && (state == IDLE);
  assign doMthi   = start && (op == MDU_MTHI) && (state == IDLE);
  assign doMtlo   = start && (op == MDU_MTLO) && (state == IDLE);

  assign busy = (state == RUN) || (start && isLong);
  assign hi   = hiQ;
  assign lo   = loQ;

  logic [2*WIDTH-1:0] aExt, bExt, prod;
  logic [WIDTH-1:0]   aMag, bMag, bSafe;
  logic [WIDTH-1:0]   qMag, rMag, quot, rem;
  logic               aNeg, bNeg, divZero;

  // Sign/magnitude divide: most-negative / -1 falls out
  // as LO = most-negative, HI = 0 without a special case.
  always_comb begin
    aExt = isSigned ? {{WIDTH{rs[WIDTH-1]}}, rs}
                    : {{WIDTH{1'b0}}, rs};
    bExt = isSigned ? {{WIDTH{rt[WIDTH-1]}}, rt}
                    : {{WIDTH{1'b0}}, rt};
    prod = aExt * bExt;

    aNeg    = isSigned && rs[WIDTH-1];
    bNeg    = isSigned && rt[WIDTH-1];
    aMag    = aNeg ? -rs : rs;
    bMag    = bNeg ? -rt : rt;
    divZero = (rt == '0);
    bSafe   = divZero ? WIDTH'(1) : bMag;
    qMag    = aMag / bSafe;
    rMag    = aMag % bSafe;
    quot    = (aNeg ^ bNeg) ? -qMag : qMag;
    rem     = aNeg ? -rMag : rMag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      hiQ   <= '0;
      loQ   <= '0;
      hiSh  <= '0;
      loSh  <= '0;
      shWe  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            launch: begin
              count <= isMul ? CNTW'(MUL_CYCLES)
                             : CNTW'(DIV_CYCLES);
              hiSh  <= isMul ? prod[2*WIDTH-1:WIDTH] : rem;
              loSh  <= isMul ? prod[WIDTH-1:0] : quot;
              shWe  <= isMul || !divZero;
              state <= RUN;
            end
            doMthi:  hiQ <= rs;
            doMtlo:  loQ <= rs;
            default: ;
          endcase
        end
        RUN: begin
          if (count == CNTW'(1)) begin
            if (shWe) begin
              hiQ <= hiSh;
              loQ <= loSh;
            end
            count <= '0;
            state <= IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_mdu.sv
// Execute stage: operand forwarding, single-cycle ALU
// and the multi-cycle multiply/divide unit.
module ex_stage_mdu
  import ex_stage_mdu_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int FWD_SRCS   = 2,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  localparam int SELW      = $clog2(FWD_SRCS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4:0]                shamt,
  input  logic [WIDTH-1:0]          regRD1_orig,
  input  logic [WIDTH-1:0]          regRD2_orig,
  input  logic [WIDTH-1:0]          imm32,
  input  logic [FWD_SRCS*WIDTH-1:0] fwdData,
  input  logic [SELW-1:0]           regRD1Forward,
  input  logic [SELW-1:0]           regRD2Forward,
  input  logic                      ALUSrcASel,
  input  logic                      ALUSrcBSel,
  input  logic [3:0]                ALUCtrl,
  input  logic [3:0]                mduOp,
  input  logic                      mduStart,
  output logic [WIDTH-1:0]          ALUResult,
  output logic [WIDTH-1:0]          regRD2,
  output logic [WIDTH-1:0]          mduOut,
  output logic                      mduBusy
);

  localparam int SHW = $clog2(WIDTH);

  // Out-of-range selects yield zero rather than aliasing.
  function automatic logic [WIDTH-1:0] fwdPick(
    input logic [SELW-1:0]           sel,
    input logic [WIDTH-1:0]          orig,
    input logic [FWD_SRCS*WIDTH-1:0] data
  );
    logic [WIDTH-1:0] v;
    v = '0;
    if (sel == '0) v = orig;
    for (int k = 0; k < FWD_SRCS; k++) begin
      if (sel == SELW'(k + 1)) v = data[k*WIDTH +: WIDTH];
    end
    return v;
  endfunction

  logic [WIDTH-1:0] regRD1;
  logic [WIDTH-1:0] aluA, aluB;
  logic [SHW-1:0]   shAmt;
  logic [WIDTH-1:0] hi, lo;

  assign regRD1 = fwdPick(regRD1Forward, regRD1_orig, fwdData);
  assign regRD2 = fwdPick(regRD2Forward, regRD2_orig, fwdData);

  assign aluA  = ALUSrcASel ? WIDTH'(shamt) : regRD1;
  assign aluB  = ALUSrcBSel ? imm32 : regRD2;
  assign shAmt = aluA[SHW-1:0];

  always_comb begin
    ALUResult = '0;
    unique case (ALUCtrl)
      ALU_AND:  ALUResult = aluA & aluB;
      ALU_OR:   ALUResult = aluA | aluB;
      ALU_ADD:  ALUResult = aluA + aluB;
      ALU_XOR:  ALUResult = aluA ^ aluB;
      ALU_SLL:  ALUResult = aluB << shAmt;
      ALU_SRL:  ALUResult = aluB >> shAmt;
      ALU_SUB:  ALUResult = aluA - aluB;
      ALU_SLT:  ALUResult =
        WIDTH'($signed(aluA) < $signed(aluB));
      ALU_SRA:  ALUResult = $signed(aluB) >>> shAmt;
      ALU_SLTU: ALUResult = WIDTH'(aluA < aluB);
      ALU_NOR:  ALUResult = ~(aluA | aluB);
      default:  ALUResult = '0;
    endcase
  end

  mdu_core #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu (
    .clk   (clk),
    .rst_n (rst_n),
    .op    (mduOp),
    .start (mduStart),
    .rs    (regRD1),
    .rt    (regRD2),
    .hi    (hi),
    .lo    (lo),
    .busy  (mduBusy)
  );

  always_comb begin
    mduOut = '0;
    if (mduOp == MDU_MFHI) mduOut = hi;
    if (mduOp == MDU_MFLO) mduOut = lo;
  end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Bench for ex_stage_mdu: ALU/forwarding vector table,
// directed MDU sequences and random MDU ops vs a model.
module tb_ex_stage_mdu;
  import ex_stage_mdu_pkg::*;

  localparam int W    = 32;
  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic          clk;
  logic          rst_n;
  logic [4:0]    shamt;
  logic [W-1:0]  regRD1_orig, regRD2_orig, imm32;
  logic [2*W-1:0] fwdData;
  logic [1:0]    regRD1Forward, regRD2Forward;
  logic          ALUSrcASel, ALUSrcBSel;
  logic [3:0]    ALUCtrl, mduOp;
  logic          mduStart;
  logic [W-1:0]  ALUResult, regRD2, mduOut;
  logic          mduBusy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] hiM, loM;

  ex_stage_mdu #(
    .WIDTH(W), .FWD_SRCS(2),
    .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .shamt(shamt),
    .regRD1_orig(regRD1_orig), .regRD2_orig(regRD2_orig),
    .imm32(imm32), .fwdData(fwdData),
    .regRD1Forward(regRD1Forward),
    .regRD2Forward(regRD2Forward),
    .ALUSrcASel(ALUSrcASel), .ALUSrcBSel(ALUSrcBSel),
    .ALUCtrl(ALUCtrl), .mduOp(mduOp), .mduStart(mduStart),
    .ALUResult(ALUResult), .regRD2(regRD2),
    .mduOut(mduOut), .mduBusy(mduBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  s1, s2;
    logic [31:0] f0, f1, o1, o2, imm;
    logic [4:0]  sh;
    logic        as, bs;
    logic [3:0]  ctrl;
    logic [31:0] expAlu, expRd2;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readHL(output logic [31:0] h,
                        output logic [31:0] l);
    mduOp = MDU_MFHI;
    #1 h = mduOut;
    mduOp = MDU_MFLO;
    #1 l = mduOut;
    mduOp = MDU_NONE;
  endtask

  task automatic checkHL(input string name,
                         input logic [31:0] eh,
                         input logic [31:0] el);
    logic [31:0] h, l;
    readHL(h, l);
    chk({name, "_hi"}, h, eh);
    chk({name, "_lo"}, l, el);
  endtask

  task automatic startOp(input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
    regRD1Forward = 2'd0;
    regRD2Forward = 2'd0;
    regRD1_orig = a;
    regRD2_orig = b;
    mduOp = op;
    mduStart = 1'b1;
    #1 chk("busyStart", 32'(mduBusy), 32'd1);
    tick();
    mduStart = 1'b0;
    mduOp = MDU_NONE;
  endtask

  // Scrambles the operand inputs every cycle of the run.
  task automatic runOut(input int n);
    for (int i = 0; i < n; i++) begin
      chk("busyRun", 32'(mduBusy), 32'd1);
      regRD1_orig = $urandom;
      regRD2_orig = $urandom;
      fwdData = {$urandom, $urandom};
      regRD1Forward = 2'($urandom_range(0, 3));
      regRD2Forward = 2'($urandom_range(0, 3));
      tick();
    end
    #1 chk("busyDone", 32'(mduBusy), 32'd0);
  endtask

  task automatic mtOp(input logic [3:0] op,
                      input logic [31:0] a);
    regRD1Forward = 2'd0;
    regRD1_orig = a;
    mduOp = op;
    mduStart = 1'b1;
    tick();
    mduStart = 1'b0;
    mduOp = MDU_NONE;
  endtask

  function automatic void model(input logic [3:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                inout logic [31:0] h,
                                inout logic [31:0] l);
    longint x, y, q, r, p;
    longint unsigned up;
    case (op)
      MDU_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        h = p[63:32];
        l = p[31:0];
      end
      MDU_MULTU: begin
        up = longint'(a) * longint'(b);
        h = up[63:32];
        l = up[31:0];
      end
      MDU_DIV: if (b != 0) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        q = x / y;
        r = x % y;
        l = q[31:0];
        h = r[31:0];
      end
      MDU_DIVU: if (b != 0) begin
        l = a / b;
        h = a % b;
      end
      MDU_MTHI: h = a;
      MDU_MTLO: l = a;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick(
    input logic [1:0] s, input logic [31:0] o,
    input logic [31:0] f0, input logic [31:0] f1);
    case (s)
      2'd0: return o;
      2'd1: return f0;
      2'd2: return f1;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b, e;
    vec_t v;

    rst_n = 1'b0;
    shamt = '0;
    regRD1_orig = '0;
    regRD2_orig = '0;
    imm32 = '0;
    fwdData = '0;
    regRD1Forward = '0;
    regRD2Forward = '0;
    ALUSrcASel = 1'b0;
    ALUSrcBSel = 1'b0;
    ALUCtrl = ALU_ADD;
    mduOp = MDU_NONE;
    mduStart = 1'b0;
    #3;
    chk("rstBusy", 32'(mduBusy), 32'd0);
    checkHL("rst", 32'h0, 32'h0);
    #10 rst_n = 1'b1;
    hiM = '0;
    loM = '0;
    tick();

    vecs.push_back('{2'd2, 2'd0, 32'h0, 32'h1234, 32'h0,
      32'h55, 32'h1, 5'd0, 1'b0, 1'b1, ALU_ADD,
      32'h1235, 32'h55});
    vecs.push_back('{2'd1, 2'd2, 32'd10, 32'd3, 32'h0,
      32'h0, 32'h0, 5'd0, 1'b0, 1'b0, ALU_SUB,
      32'd7, 32'd3});
    vecs.push_back('{2'd3, 2'd3, 32'h1, 32'h2, 32'hDEAD,
      32'hBEEF, 32'hF0, 5'd0, 1'b0, 1'b1, ALU_OR,
      32'hF0, 32'h0});
    vecs.push_back('{2'd0, 2'd0, 32'h0, 32'h0, 32'h77,
      32'h1, 32'h0, 5'd4, 1'b1, 1'b0, ALU_SLL,
      32'h10, 32'h1});
    vecs.push_back('{2'd0, 2'd0, 32'h0, 32'h0, 32'h0,
      32'h80000000, 32'h0, 5'd4, 1'b1, 1'b0, ALU_SRA,
      32'hF8000000, 32'h80000000});
    vecs.push_back('{2'd0, 2'd0, 32'h0, 32'h0, 32'h0,
      32'h80000000, 32'h0, 5'd4, 1'b1, 1'b0, ALU_SRL,
      32'h08000000, 32'h80000000});
    vecs.push_back('{2'd0, 2'd0, 32'h0, 32'h0,
      32'hFFFFFFFF, 32'h1, 32'h0, 5'd0, 1'b0, 1'b0,
      ALU_SLT, 32'h1, 32'h1});
    vecs.push_back('{2'd0, 2'd0, 32'h0, 32'h0,
      32'hFFFFFFFF, 32'h1, 32'h0, 5'd0, 1'b0, 1'b0,
      ALU_SLTU, 32'h0, 32'h1});
    vecs.push_back('{2'd0, 2'd0, 32'h0, 32'h0, 32'hF0F0,
      32'hFF00, 32'h0, 5'd0, 1'b0, 1'b0, ALU_AND,
      32'hF000, 32'hFF00});
    vecs.push_back('{2'd0, 2'd0, 32'h0, 32'h0, 32'hF0F0,
      32'hFF00, 32'h0, 5'd0, 1'b0, 1'b0, ALU_XOR,
      32'h0FF0, 32'hFF00});
    vecs.push_back('{2'd0, 2'd0, 32'h0, 32'h0, 32'h0,
      32'h0, 32'h0, 5'd0, 1'b0, 1'b0, ALU_NOR,
      32'hFFFFFFFF, 32'h0});
    vecs.push_back('{2'd1, 2'd1, 32'h40, 32'h9, 32'h1,
      32'h2, 32'h0, 5'd0, 1'b0, 1'b0, ALU_ADD,
      32'h80, 32'h40});

    foreach (vecs[i]) begin
      v = vecs[i];
      regRD1Forward = v.s1;
      regRD2Forward = v.s2;
      fwdData = {v.f1, v.f0};
      regRD1_orig = v.o1;
      regRD2_orig = v.o2;
      imm32 = v.imm;
      shamt = v.sh;
      ALUSrcASel = v.as;
      ALUSrcBSel = v.bs;
      ALUCtrl = v.ctrl;
      #1;
      chk($sformatf("alu%0d", i), ALUResult, v.expAlu);
      chk($sformatf("rd2_%0d", i), regRD2, v.expRd2);
    end

    ALUSrcASel = 1'b0;
    ALUSrcBSel = 1'b0;
    for (int i = 0; i < 20; i++) begin
      regRD1Forward = 2'($urandom_range(0, 3));
      regRD2Forward = 2'($urandom_range(0, 3));
      fwdData = {$urandom, $urandom};
      regRD1_orig = $urandom;
      regRD2_orig = $urandom;
      ALUCtrl = (i % 2 == 0) ? ALU_ADD : ALU_SUB;
      #1;
      a = pick(regRD1Forward, regRD1_orig,
               fwdData[31:0], fwdData[63:32]);
      b = pick(regRD2Forward, regRD2_orig,
               fwdData[31:0], fwdData[63:32]);
      e = (i % 2 == 0) ? a + b : a - b;
      chk("randAlu", ALUResult, e);
      chk("randRd2", regRD2, b);
    end
    tick();

    startOp(MDU_MULT, -32'sd3, 32'd7);
    runOut(MULN);
    checkHL("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);
    hiM = 32'hFFFFFFFF;
    loM = 32'hFFFFFFEB;

    startOp(MDU_DIV, -32'sd7, 32'd2);
    runOut(DIVN);
    checkHL("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    startOp(MDU_DIVU, 32'd7, 32'd0);
    runOut(DIVN);
    checkHL("divz", 32'hFFFFFFFF, 32'hFFFFFFFD);

    startOp(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    runOut(DIVN);
    checkHL("divOvf", 32'h0, 32'h80000000);

    mtOp(MDU_MTLO, 32'hA5A5A5A5);
    mduOp = MDU_MFLO;
    mduStart = 1'b1;
    #1 chk("mfloAfterMt", mduOut, 32'hA5A5A5A5);
    mduStart = 1'b0;
    checkHL("mtlo", 32'h0, 32'hA5A5A5A5);

    mtOp(MDU_MTHI, 32'h1111);
    startOp(MDU_MULTU, 32'hFFFF, 32'hFFFF);
    tick();
    rst_n = 1'b0;
    #1 chk("rstMidBusy", 32'(mduBusy), 32'd0);
    checkHL("rstMid", 32'h0, 32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("rstAfterBusy", 32'(mduBusy), 32'd0);
    checkHL("rstAfter", 32'h0, 32'h0);

    startOp(MDU_MULT, 32'd6, -32'sd2);
    chk("busyRun", 32'(mduBusy), 32'd1);
    tick();
    regRD1_orig = 32'd100;
    regRD2_orig = 32'd7;
    mduOp = MDU_DIV;
    mduStart = 1'b1;
    #1 chk("busyIntr", 32'(mduBusy), 32'd1);
    tick();
    mduStart = 1'b0;
    mduOp = MDU_NONE;
    runOut(MULN - 2);
    checkHL("ignored", 32'hFFFFFFFF, 32'hFFFFFFF4);
    hiM = 32'hFFFFFFFF;
    loM = 32'hFFFFFFF4;

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: op = MDU_MULT;
        1: op = MDU_MULTU;
        2: op = MDU_DIV;
        3: op = MDU_DIVU;
        4: op = MDU_MTHI;
        default: op = MDU_MTLO;
      endcase
      a = randOperand();
      b = randOperand();
      if (op == MDU_MTHI || op == MDU_MTLO) begin
        mtOp(op, a);
      end else begin
        startOp(op, a, b);
        runOut((op == MDU_MULT || op == MDU_MULTU)
               ? MULN : DIVN);
      end
      model(op, a, b, hiM, loM);
      checkHL($sformatf("rand%0d", i), hiM, loM);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
